// File: rtl/grid_pattern_loader.sv
// ----------------------------------------------------------------------------
// grid_pattern_loader
//
// Purpose:
//   Drives the programming interface of the 7x7 game-of-life datapath the way
//   an operator would. The datapath is first put into PROGRAM. One cell is then
//   written per step, using the write-alive or write-dead button. After a short
//   settle period the grid is handed over to RUN.
//   All outputs are registered.
//
// Ports:
//   clka       system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a load; only honoured in IDLE or DONE
//   abort      cancel any load and return to IDLE; wins over start
//   pattern    seed pattern; bit i is cell i, 1 = alive
//   state_out  datapath state: 00 idle, 01 program, 10 run
//   btn0       write-dead strobe
//   btn1       write-alive strobe
//   busy       high while loading (SETUP, CELL, SETTLE)
//   done       high in DONE
//
// Optional build macro GRID_LOADER_VERIFY_EN:
//   Adds the input grid (datapath readback) and the output load_err.
//   load_err flags a difference between the readback and the latched pattern.
//   It is sampled on the last SETTLE cycle and is valid from the first DONE
//   cycle. It is cleared by start or abort.
// ----------------------------------------------------------------------------
module grid_pattern_loader #(
   parameter int N_CELLS       = 49,
   parameter int SETUP_CYCLES  = 2,
   parameter int CELL_CYCLES   = 1,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic               clka,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [N_CELLS-1:0] pattern,
`ifdef GRID_LOADER_VERIFY_EN
   input  logic [N_CELLS-1:0] grid,
   output logic               load_err,
`endif
   output logic [1:0]         state_out,
   output logic               btn0,
   output logic               btn1,
   output logic               busy,
   output logic               done
);

   localparam int IDX_W    = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
   localparam int MAX_HOLD = (SETUP_CYCLES > CELL_CYCLES)
                             ? ((SETUP_CYCLES > SETTLE_CYCLES) ? SETUP_CYCLES : SETTLE_CYCLES)
                             : ((CELL_CYCLES > SETTLE_CYCLES) ? CELL_CYCLES : SETTLE_CYCLES);
   localparam int CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_CELL   = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]         fsm_q, fsm_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [N_CELLS-1:0] pat_q, pat_d;
   logic [1:0]         state_out_q, state_out_d;
   logic               btn0_q, btn0_d;
   logic               btn1_q, btn1_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // Next-state logic
   always_comb begin
      fsm_d = fsm_q;
      idx_d = idx_q;
      cnt_d = cnt_q;
      pat_d = pat_q;
      case (fsm_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               pat_d = pattern;
               fsm_d = S_SETUP;
               cnt_d = '0;
               idx_d = '0;
            end
         end
         S_SETUP: begin
            if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
               fsm_d = S_CELL;
               cnt_d = '0;
               idx_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_CELL: begin
            if (cnt_q == CNT_W'(CELL_CYCLES - 1)) begin
               cnt_d = '0;
               // The last cell leaves the index in place, so it never wraps
               // inside a load.
               if (idx_q == IDX_W'(N_CELLS - 1)) begin
                  fsm_d = S_SETTLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
               fsm_d = S_DONE;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            fsm_d = S_IDLE;
            cnt_d = '0;
            idx_d = '0;
         end
      endcase
      if (abort) begin
         fsm_d = S_IDLE;
         idx_d = '0;
         cnt_d = '0;
      end
   end

   // The outputs are decoded from the next state, so that the registered
   // outputs line up with the FSM. Because of this, an abort clears the
   // buttons in the very next cycle.
   always_comb begin
      state_out_d = 2'b00;
      btn0_d      = 1'b0;
      btn1_d      = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      case (fsm_d)
         S_SETUP, S_SETTLE: begin
            state_out_d = 2'b01;
            busy_d      = 1'b1;
         end
         S_CELL: begin
            state_out_d = 2'b01;
            busy_d      = 1'b1;
            btn1_d      = pat_d[idx_d];
            btn0_d      = ~pat_d[idx_d];
         end
         S_DONE: begin
            state_out_d = 2'b10;
            done_d      = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q       <= S_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         pat_q       <= '0;
         state_out_q <= 2'b00;
         btn0_q      <= 1'b0;
         btn1_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         pat_q       <= pat_d;
         state_out_q <= state_out_d;
         btn0_q      <= btn0_d;
         btn1_q      <= btn1_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign state_out = state_out_q;
   assign btn0      = btn0_q;
   assign btn1      = btn1_q;
   assign busy      = busy_q;
   assign done      = done_q;

`ifdef GRID_LOADER_VERIFY_EN
   logic load_err_q, load_err_d;

   always_comb begin
      load_err_d = load_err_q;
      // The readback is compared on the transition from SETTLE to DONE.
      if (fsm_q == S_SETTLE && fsm_d == S_DONE) begin
         load_err_d = (grid != pat_q);
      end
      if (((fsm_q == S_IDLE) || (fsm_q == S_DONE)) && start) begin
         load_err_d = 1'b0;
      end
      if (abort) begin
         load_err_d = 1'b0;
      end
   end

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         load_err_q <= 1'b0;
      end else begin
         load_err_q <= load_err_d;
      end
   end

   assign load_err = load_err_q;
`endif

endmodule

// File: tb/tb_grid_pattern_loader.sv
// ----------------------------------------------------------------------------
// tb_grid_pattern_loader
//
// Directed bench for grid_pattern_loader with the default parameters.
//
// Each load pushes its expected write-alive bit sequence into a scoreboard
// queue. A monitor pops one entry for every button strobe the DUT presents.
//
// The stimulus thread also checks the full output vector in every cycle
// against the hand-derived timeline.
// Cycle numbering: start is sampled at edge 0, and cycle k is the clock
// period that follows edge k-1:
//   cycles 1..2  setup
//   cycles 3..51 cells 0..48
//   cycles 52..53 settle
//   cycle 54 onward done
// ----------------------------------------------------------------------------
module tb_grid_pattern_loader;

   logic        clka = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [48:0] pattern = '0;
   logic [1:0]  state_out;
   logic        btn0, btn1, busy, done;
`ifdef GRID_LOADER_VERIFY_EN
   logic [48:0] grid = '0;
   logic        load_err;
`endif

   int checks = 0;
   int errors = 0;
   int n_btn0 = 0;
   int n_btn1 = 0;
   int n_loads = 0;
   logic exp_q[$];

   always #5 clka = ~clka;

   grid_pattern_loader dut (
      .clka      (clka),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .pattern   (pattern),
`ifdef GRID_LOADER_VERIFY_EN
      .grid      (grid),
      .load_err  (load_err),
`endif
      .state_out (state_out),
      .btn0      (btn0),
      .btn1      (btn1),
      .busy      (busy),
      .done      (done)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected output vector {state_out, btn0, btn1, busy, done} in cycle c.
   function automatic logic [5:0] exp_vec(input int c, input logic [48:0] p);
      logic [5:0] v;
      if (c <= 0)            v = 6'b00_0_0_0_0;
      else if (c <= 2)       v = 6'b01_0_0_1_0;
      else if (c <= 51)      v = {2'b01, ~p[c-3], p[c-3], 1'b1, 1'b0};
      else if (c <= 53)      v = 6'b01_0_0_1_0;
      else                   v = 6'b10_0_0_0_1;
      return v;
   endfunction

   function automatic logic [5:0] act_vec();
      return {state_out, btn0, btn1, busy, done};
   endfunction

   // Scoreboard monitor: every strobe must match the next expected cell.
   always @(negedge clka) begin
      if (rst_n && (btn0 || btn1)) begin
         if (btn0) n_btn0++;
         if (btn1) n_btn1++;
         chk("btn_exclusive", {63'd0, btn0 & btn1}, 64'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", 64'd1, 64'd0);
         end else begin
            chk("strobe_btn1", {63'd0, btn1}, {63'd0, exp_q.pop_front()});
         end
      end
   end

   // Queues the expected cells, pulses start, and returns #1 after edge 0.
   task automatic start_load(input logic [48:0] p);
      for (int i = 0; i < 49; i++) exp_q.push_back(p[i]);
      pattern = p;
      start   = 1'b1;
      @(posedge clka);
      #1 start = 1'b0;
   endtask

   task automatic run_cycles(input logic [48:0] p, input int first, input int last);
      for (int c = first; c <= last; c++) begin
         @(negedge clka);
         chk($sformatf("cycle%0d_vec", c), {58'd0, act_vec()}, {58'd0, exp_vec(c, p)});
      end
      n_loads++;
      $display("load %0d pattern=%013h cycles %0d..%0d", n_loads, p, first, last);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [48:0] p;

      // Reset held low with random inputs
      for (int i = 0; i < 5; i++) begin
         @(negedge clka);
         start   = 1'($urandom);
         abort   = 1'($urandom);
         pattern = {17'($urandom), 32'($urandom)};
         #1 chk("reset_vec", {58'd0, act_vec()}, 64'd0);
      end
      start = 1'b0;
      abort = 1'b0;
      @(posedge clka);
      #1 rst_n = 1'b1;
      @(negedge clka);
      chk("post_reset_vec", {58'd0, act_vec()}, 64'd0);

      // Single alive cell: full cycle-accurate timeline
      p = 49'h1;
      start_load(p);
      run_cycles(p, 1, 56);

      // Alternating pattern started from DONE, with popcount checks
      n_btn0 = 0;
      n_btn1 = 0;
      p = 49'h0AAAA_AAAA_AAAA;
      start_load(p);
      run_cycles(p, 1, 55);
      chk("btn1_count", 64'(n_btn1), 64'd24);
      chk("btn0_count", 64'(n_btn0), 64'd25);

      // Abort in the cycle that strobes cell 20 (cycle 23)
      p = 49'h1_2345_6789_ABCD;
      start_load(p);
      run_cycles(p, 1, 23);
      abort = 1'b1;
      @(posedge clka);
      #1 abort = 1'b0;
      exp_q.delete();
      @(negedge clka);
      chk("abort_vec", {58'd0, act_vec()}, 64'd0);
      @(negedge clka);
      chk("abort_idle_vec", {58'd0, act_vec()}, 64'd0);
      // A new start reloads all cells from index 0
      start_load(p);
      run_cycles(p, 1, 55);

      // start pulses and pattern changes during CELL are ignored
      p = 49'h0_F0F0_3C3C_5A5A;
      start_load(p);
      for (int c = 1; c <= 55; c++) begin
         @(negedge clka);
         chk($sformatf("ign_cycle%0d_vec", c), {58'd0, act_vec()}, {58'd0, exp_vec(c, p)});
         if (c >= 10 && c <= 20) begin
            start   = 1'b1;
            pattern = ~p;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      n_loads++;
      $display("load %0d pattern=%013h with start/pattern noise in CELL", n_loads, p);

      // Asynchronous reset during CELL clears the outputs at once
      p = 49'h1_FFFF_FFFF_FFFF;
      start_load(p);
      run_cycles(p, 1, 10);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_vec", {58'd0, act_vec()}, 64'd0);
      exp_q.delete();
      @(posedge clka);
      #1 rst_n = 1'b1;
      @(negedge clka);
      chk("after_async_reset_vec", {58'd0, act_vec()}, 64'd0);

`ifdef GRID_LOADER_VERIFY_EN
      p = 49'h0_1234_5678_9ABC;
      grid = p;
      start_load(p);
      run_cycles(p, 1, 54);
      chk("load_err_match", {63'd0, load_err}, 64'd0);
      grid = p ^ 49'h20;
      start_load(p);
      run_cycles(p, 1, 54);
      chk("load_err_bit5", {63'd0, load_err}, 64'd1);
      start_load(p);
      @(negedge clka);
      chk("load_err_cleared", {63'd0, load_err}, 64'd0);
      run_cycles(p, 2, 54);
      chk("load_err_bit5_again", {63'd0, load_err}, 64'd1);
`endif

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
